// File: rtl/ethernet_tx_frame_builder_if.sv
// Stream bundle for the TX frame builder: raw frame bytes in, 9-bit shipper stream out,
// plus per-frame status pulses.
interface ethernet_tx_frame_builder_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   logic [8:0] out_data;
   logic       out_data_enable;
   logic       out_data_ready;
   logic       frame_done;
   logic       frame_truncated;

   modport slave (
      input  in_data, in_valid, in_last, out_data_ready,
      output in_ready, out_data, out_data_enable, frame_done, frame_truncated
   );

   modport master (
      output in_data, in_valid, in_last, out_data_ready,
      input  in_ready, out_data, out_data_enable, frame_done, frame_truncated
   );
endinterface

// File: rtl/ethernet_tx_frame_builder.sv
// Ethernet TX frame builder: pads short frames with 0x00, truncates long ones and (when
// ETHERNET_TX_FRAME_BUILDER_FCS_EN is defined) appends the CRC-32 FCS, LSB first.
module ethernet_tx_frame_builder #(
   parameter int unsigned MIN_FRAME_BYTES = 60,
   parameter int unsigned MAX_FRAME_BYTES = 1514
) (
   input logic                        clock,
   input logic                        reset,
   ethernet_tx_frame_builder_if.slave bus
);
   typedef enum logic [2:0] {StIdle, StPayload, StDiscard, StPad, StFcs} state_t;

   localparam logic [10:0] MinCount = 11'(MIN_FRAME_BYTES);
   localparam logic [10:0] MaxCount = 11'(MAX_FRAME_BYTES);

   // Where a frame goes once its data (payload + pad) is complete.
`ifdef ETHERNET_TX_FRAME_BUILDER_FCS_EN
   localparam state_t EndState = StFcs;
   localparam logic   EndLast  = 1'b0;
`else
   localparam state_t EndState = StIdle;
   localparam logic   EndLast  = 1'b1;
`endif

   state_t      state_q, state_d;
   logic [8:0]  out_data_q, out_data_d;
   logic        out_en_q, out_en_d;
   logic        out_last_q, out_last_d;
   logic [10:0] count_q, count_d;
   logic        done_q, done_d;
   logic        trunc_q, trunc_d;
   logic        can_load;
   logic        accept;
   logic [10:0] count_inc;

`ifdef ETHERNET_TX_FRAME_BUILDER_FCS_EN
   logic [31:0] crc_q, crc_d;
   logic [1:0]  fcs_idx_q, fcs_idx_d;
   logic [31:0] fcs_word;
   logic [7:0]  fcs_byte;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int k = 0; k < 8; k++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   assign fcs_word = ~crc_q;
   assign fcs_byte = fcs_word[{fcs_idx_q, 3'b000} +: 8];
`endif

   // The output register can take a new byte whenever it is empty or draining this cycle.
   assign can_load  = !out_en_q || bus.out_data_ready;
   assign count_inc = (state_q == StIdle) ? 11'd1 : count_q + 11'd1;

   assign bus.in_ready = !reset && ((state_q == StDiscard) ||
                         (((state_q == StIdle) || (state_q == StPayload)) && can_load));
   assign accept       = bus.in_valid && bus.in_ready;

   assign bus.out_data        = out_data_q;
   assign bus.out_data_enable = out_en_q;
   assign bus.frame_done      = done_q;
   assign bus.frame_truncated = trunc_q;

   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      out_en_d   = out_en_q && !bus.out_data_ready;
      out_last_d = out_last_q;
      count_d    = count_q;
      trunc_d    = 1'b0;
      done_d     = out_en_q && bus.out_data_ready && out_last_q;
`ifdef ETHERNET_TX_FRAME_BUILDER_FCS_EN
      crc_d      = crc_q;
      fcs_idx_d  = fcs_idx_q;
`endif
      unique case (state_q)
         StIdle, StPayload: begin
            if (accept) begin
               out_data_d = {state_q == StIdle, bus.in_data};
               out_en_d   = 1'b1;
               out_last_d = 1'b0;
               count_d    = count_inc;
`ifdef ETHERNET_TX_FRAME_BUILDER_FCS_EN
               crc_d      = crc_byte(crc_q, bus.in_data);
`endif
               if (bus.in_last) begin
                  if (count_inc < MinCount) begin
                     state_d = StPad;
                  end else begin
                     state_d    = EndState;
                     out_last_d = EndLast;
                  end
               end else if (count_inc == MaxCount) begin
                  // Treat this byte as the last one and swallow the rest of the input frame.
                  trunc_d    = 1'b1;
                  state_d    = StDiscard;
                  out_last_d = EndLast;
               end else begin
                  state_d = StPayload;
               end
            end
         end
         StDiscard: begin
            if (bus.in_valid && bus.in_last) begin
               state_d = (count_q < MinCount) ? StPad : EndState;
            end
         end
         StPad: begin
            if (can_load) begin
               out_data_d = 9'h000;
               out_en_d   = 1'b1;
               out_last_d = 1'b0;
               count_d    = count_inc;
`ifdef ETHERNET_TX_FRAME_BUILDER_FCS_EN
               crc_d      = crc_byte(crc_q, 8'h00);
`endif
               if (count_inc >= MinCount) begin
                  state_d    = EndState;
                  out_last_d = EndLast;
               end
            end
         end
`ifdef ETHERNET_TX_FRAME_BUILDER_FCS_EN
         StFcs: begin
            if (can_load) begin
               out_data_d = {1'b0, fcs_byte};
               out_en_d   = 1'b1;
               out_last_d = (fcs_idx_q == 2'd3);
               fcs_idx_d  = fcs_idx_q + 2'd1;
               if (fcs_idx_q == 2'd3) begin
                  state_d = StIdle;
                  crc_d   = 32'hFFFF_FFFF;
               end
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         out_data_q <= '0;
         out_en_q   <= 1'b0;
         out_last_q <= 1'b0;
         count_q    <= '0;
         done_q     <= 1'b0;
         trunc_q    <= 1'b0;
`ifdef ETHERNET_TX_FRAME_BUILDER_FCS_EN
         crc_q      <= 32'hFFFF_FFFF;
         fcs_idx_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
         out_en_q   <= out_en_d;
         out_last_q <= out_last_d;
         count_q    <= count_d;
         done_q     <= done_d;
         trunc_q    <= trunc_d;
`ifdef ETHERNET_TX_FRAME_BUILDER_FCS_EN
         crc_q      <= crc_d;
         fcs_idx_q  <= fcs_idx_d;
`endif
      end
   end
endmodule

// File: tb/tb_ethernet_tx_frame_builder.sv
// Directed bench for ethernet_tx_frame_builder: two instances (MIN=9/MAX=64 and defaults)
// share stimulus; sel picks which one is driven and observed.
module tb_ethernet_tx_frame_builder;
`ifdef ETHERNET_TX_FRAME_BUILDER_FCS_EN
   localparam int FcsLen = 4;
`else
   localparam int FcsLen = 0;
`endif
   localparam int MinA = 9;
   localparam int MaxA = 64;
   localparam int MinB = 60;
   localparam int MaxB = 1514;

   logic       clock     = 1'b0;
   logic       reset     = 1'b1;
   logic       sel       = 1'b0;
   logic [7:0] in_data   = 8'h00;
   logic       in_valid  = 1'b0;
   logic       in_last   = 1'b0;
   logic       ready_cfg = 1'b1;
   logic       rand_mode = 1'b0;
   logic       rand_bit  = 1'b1;
   logic       out_ready;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   always @(posedge clock) begin
      #1;
      rand_bit = 1'($urandom_range(0, 1));
   end

   assign out_ready = rand_mode ? rand_bit : ready_cfg;

   ethernet_tx_frame_builder_if ifa ();
   ethernet_tx_frame_builder_if ifb ();

   assign ifa.in_data        = in_data;
   assign ifa.in_valid       = in_valid && !sel;
   assign ifa.in_last        = in_last;
   assign ifa.out_data_ready = out_ready;
   assign ifb.in_data        = in_data;
   assign ifb.in_valid       = in_valid && sel;
   assign ifb.in_last        = in_last;
   assign ifb.out_data_ready = out_ready;

   ethernet_tx_frame_builder #(.MIN_FRAME_BYTES(MinA), .MAX_FRAME_BYTES(MaxA)) dut_a (
      .clock(clock), .reset(reset), .bus(ifa)
   );
   ethernet_tx_frame_builder #(.MIN_FRAME_BYTES(MinB), .MAX_FRAME_BYTES(MaxB)) dut_b (
      .clock(clock), .reset(reset), .bus(ifb)
   );

   logic       obs_in_ready, obs_en, obs_done, obs_trunc;
   logic [8:0] obs_data;
   assign obs_in_ready = sel ? ifb.in_ready : ifa.in_ready;
   assign obs_en       = sel ? ifb.out_data_enable : ifa.out_data_enable;
   assign obs_data     = sel ? ifb.out_data : ifa.out_data;
   assign obs_done     = sel ? ifb.frame_done : ifa.frame_done;
   assign obs_trunc    = sel ? ifb.frame_truncated : ifa.frame_truncated;

   // Transfer monitor: samples on the falling edge, what the next rising edge will commit.
   logic [8:0] got[$];
   int         got_cyc[$];
   int         cyc        = 0;
   int         done_cnt   = 0;
   int         done_pos   = 0;
   int         trunc_cnt  = 0;
   int         stall_err  = 0;
   int         stall_cnt  = 0;
   logic       stall_prev = 1'b0;
   logic [8:0] stall_data = 9'h000;

   always @(negedge clock) begin
      cyc++;
      if (reset) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev && (!obs_en || obs_data !== stall_data)) stall_err++;
         if (obs_done) begin
            done_cnt++;
            done_pos = got.size();
         end
         if (obs_trunc) trunc_cnt++;
         if (obs_en && out_ready) begin
            got.push_back(obs_data);
            got_cyc.push_back(cyc);
         end
         if (obs_en && !out_ready) stall_cnt++;
         stall_prev = obs_en && !out_ready;
         stall_data = obs_data;
      end
   end

   logic [8:0] tx[$];
   logic [8:0] exp[$];

   function automatic void add_frame(input int len, input int mul, input int off);
      for (int i = 0; i < len; i++) tx.push_back({i == len - 1, 8'(i * mul + off)});
   endfunction

`ifdef ETHERNET_TX_FRAME_BUILDER_FCS_EN
   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction
`endif

   // Appends the expected output of the frame tx[start +: len] to exp.
   function automatic void build_exp(input int start, input int len, input int min_b,
                                     input int max_b);
      int n;
`ifdef ETHERNET_TX_FRAME_BUILDER_FCS_EN
      logic [31:0] crc;
      crc = 32'hFFFF_FFFF;
`endif
      n = (len < max_b) ? len : max_b;
      for (int i = 0; i < n; i++) begin
         exp.push_back({i == 0, tx[start + i][7:0]});
`ifdef ETHERNET_TX_FRAME_BUILDER_FCS_EN
         crc = crc_step(crc, tx[start + i][7:0]);
`endif
      end
      for (int i = n; i < min_b; i++) begin
         exp.push_back(9'h000);
`ifdef ETHERNET_TX_FRAME_BUILDER_FCS_EN
         crc = crc_step(crc, 8'h00);
`endif
      end
`ifdef ETHERNET_TX_FRAME_BUILDER_FCS_EN
      crc = ~crc;
      for (int k = 0; k < 4; k++) exp.push_back({1'b0, crc[8 * k +: 8]});
`endif
   endfunction

   function automatic int first_diff(input int base);
      for (int i = 0; i < exp.size(); i++) begin
         if (base + i >= got.size()) return i;
         if (got[base + i] !== exp[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [8:0] got_at(input int idx);
      if (idx < got.size()) return got[idx];
      return 9'bx;
   endfunction

   // Called at posedge+1; returns at posedge+1 with inputs idle.
   task automatic drive_tx();
      int tries;
      bit rdy;
      for (int i = 0; i < tx.size(); i++) begin
         tries    = 0;
         rdy      = 1'b0;
         in_data  = tx[i][7:0];
         in_last  = tx[i][8];
         in_valid = 1'b1;
         while (!rdy && tries < 500) begin
            @(negedge clock);
            rdy = obs_in_ready;
            @(posedge clock);
            #1;
            tries++;
         end
         if (!rdy) begin
            vectors++;
            miscompares++;
            $display("FAIL drive_timeout: byte %0d in_ready stayed 0, required 1", i);
            break;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_drain(input int target, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clock);
         if (got.size() >= target) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (4) @(negedge clock);
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clock);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         vectors++;
         if (obs_en !== 1'b0) begin
            miscompares++; $display("FAIL rst_enable[%0d]: got %b, expected 0", s, obs_en);
         end
         vectors++;
         if (obs_in_ready !== 1'b0) begin
            miscompares++; $display("FAIL rst_in_ready[%0d]: got %b, expected 0", s, obs_in_ready);
         end
         vectors++;
         if (obs_data !== 9'h000) begin
            miscompares++; $display("FAIL rst_data[%0d]: got %h, expected 000", s, obs_data);
         end
         vectors++;
         if ({obs_done, obs_trunc} !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_pulses[%0d]: got %b, expected 00", s, {obs_done, obs_trunc});
         end
      end
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      vectors++;
      if (obs_in_ready !== 1'b1) begin
         miscompares++; $display("FAIL idle_in_ready: got %b, expected 1", obs_in_ready);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_crc_vector();
      int base, dbase, tbase, d;
      bit ok;
      sel   = 1'b0;
      base  = got.size();
      dbase = done_cnt;
      tbase = trunc_cnt;
      tx.delete();
      add_frame(9, 1, 8'h31);
      exp.delete();
      exp = '{9'h131, 9'h032, 9'h033, 9'h034, 9'h035, 9'h036, 9'h037, 9'h038, 9'h039};
`ifdef ETHERNET_TX_FRAME_BUILDER_FCS_EN
      exp.push_back(9'h026);
      exp.push_back(9'h039);
      exp.push_back(9'h0F4);
      exp.push_back(9'h0CB);
`endif
      drive_tx();
      wait_drain(base + 9 + FcsLen, ok);
      vectors++;
      if (ok !== 1'b1) begin
         miscompares++; $display("FAIL crc_drain: got %0d bytes, expected %0d", got.size() - base, 9 + FcsLen);
      end
      vectors++;
      if (got.size() - base !== 9 + FcsLen) begin
         miscompares++; $display("FAIL crc_len: got %0d, expected %0d", got.size() - base, 9 + FcsLen);
      end
      d = first_diff(base);
      vectors++;
      if (d !== -1) begin
         miscompares++;
         $display("FAIL crc_data[%0d]: got %h, expected %h", d, got_at(base + d), exp[d]);
      end
      vectors++;
      if (done_cnt - dbase !== 1) begin
         miscompares++; $display("FAIL crc_done_count: got %0d, expected 1", done_cnt - dbase);
      end
      vectors++;
      if (done_pos !== base + 9 + FcsLen) begin
         miscompares++; $display("FAIL crc_done_pos: got %0d, expected %0d", done_pos, base + 9 + FcsLen);
      end
      vectors++;
      if (trunc_cnt - tbase !== 0) begin
         miscompares++; $display("FAIL crc_trunc: got %0d, expected 0", trunc_cnt - tbase);
      end
   endtask

   task automatic test_min_pad();
      int base, dbase, d;
      bit ok;
      sel   = 1'b1;
      base  = got.size();
      dbase = done_cnt;
      tx.delete();
      tx.push_back(9'h1AB);
      exp.delete();
      build_exp(0, 1, MinB, MaxB);
      drive_tx();
      wait_drain(base + 60 + FcsLen, ok);
      vectors++;
      if (got.size() - base !== 60 + FcsLen) begin
         miscompares++; $display("FAIL pad_len: got %0d, expected %0d", got.size() - base, 60 + FcsLen);
      end
      vectors++;
      if (got_at(base) !== 9'h1AB) begin
         miscompares++; $display("FAIL pad_first: got %h, expected 1ab", got_at(base));
      end
      vectors++;
      if (got_at(base + 59) !== 9'h000) begin
         miscompares++; $display("FAIL pad_last_pad: got %h, expected 000", got_at(base + 59));
      end
      d = first_diff(base);
      vectors++;
      if (d !== -1) begin
         miscompares++;
         $display("FAIL pad_data[%0d]: got %h, expected %h", d, got_at(base + d), exp[d]);
      end
      vectors++;
      if (done_cnt - dbase !== 1) begin
         miscompares++; $display("FAIL pad_done: got %0d, expected 1", done_cnt - dbase);
      end
   endtask

   task automatic test_backpressure();
      int base, dbase, serr, scnt, d;
      bit ok;
      sel       = 1'b1;
      base      = got.size();
      dbase     = done_cnt;
      serr      = stall_err;
      scnt      = stall_cnt;
      rand_mode = 1'b1;
      tx.delete();
      add_frame(100, 37, 5);
      exp.delete();
      build_exp(0, 100, MinB, MaxB);
      drive_tx();
      wait_drain(base + 100 + FcsLen, ok);
      rand_mode = 1'b0;
      vectors++;
      if (got.size() - base !== 100 + FcsLen) begin
         miscompares++; $display("FAIL bp_len: got %0d, expected %0d", got.size() - base, 100 + FcsLen);
      end
      d = first_diff(base);
      vectors++;
      if (d !== -1) begin
         miscompares++;
         $display("FAIL bp_data[%0d]: got %h, expected %h", d, got_at(base + d), exp[d]);
      end
      vectors++;
      if (stall_err - serr !== 0) begin
         miscompares++; $display("FAIL bp_stable: got %0d unstable stalls, expected 0", stall_err - serr);
      end
      vectors++;
      if (stall_cnt - scnt <= 0) begin
         miscompares++; $display("FAIL bp_stalled: got %0d stall cycles, expected >0", stall_cnt - scnt);
      end
      vectors++;
      if (done_cnt - dbase !== 1) begin
         miscompares++; $display("FAIL bp_done: got %0d, expected 1", done_cnt - dbase);
      end
   endtask

   task automatic test_truncate();
      int base, dbase, tbase, d;
      bit ok;
      sel = 1'b0;
      // Over-long frame: 80 bytes in, only the first 64 go out.
      base  = got.size();
      dbase = done_cnt;
      tbase = trunc_cnt;
      tx.delete();
      add_frame(80, 11, 8'h5A);
      exp.delete();
      build_exp(0, 80, MinA, MaxA);
      drive_tx();
      wait_drain(base + 64 + FcsLen, ok);
      vectors++;
      if (got.size() - base !== 64 + FcsLen) begin
         miscompares++; $display("FAIL trunc_len: got %0d, expected %0d", got.size() - base, 64 + FcsLen);
      end
      d = first_diff(base);
      vectors++;
      if (d !== -1) begin
         miscompares++;
         $display("FAIL trunc_data[%0d]: got %h, expected %h", d, got_at(base + d), exp[d]);
      end
      vectors++;
      if (trunc_cnt - tbase !== 1) begin
         miscompares++; $display("FAIL trunc_pulse: got %0d, expected 1", trunc_cnt - tbase);
      end
      vectors++;
      if (done_cnt - dbase !== 1) begin
         miscompares++; $display("FAIL trunc_done: got %0d, expected 1", done_cnt - dbase);
      end
      // Short frame right after: must start clean and be padded to 9.
      base  = got.size();
      tbase = trunc_cnt;
      tx.delete();
      add_frame(5, 3, 8'hC0);
      exp.delete();
      build_exp(0, 5, MinA, MaxA);
      drive_tx();
      wait_drain(base + 9 + FcsLen, ok);
      d = first_diff(base);
      vectors++;
      if (d !== -1 || got.size() - base !== 9 + FcsLen) begin
         miscompares++;
         $display("FAIL after_trunc_data[%0d]: got %h, expected %h", d, got_at(base + d), exp[d]);
      end
      // Last arriving exactly at MAX is a normal end, not a truncation.
      base  = got.size();
      tx.delete();
      add_frame(64, 5, 8'h01);
      exp.delete();
      build_exp(0, 64, MinA, MaxA);
      drive_tx();
      wait_drain(base + 64 + FcsLen, ok);
      d = first_diff(base);
      vectors++;
      if (d !== -1 || got.size() - base !== 64 + FcsLen) begin
         miscompares++;
         $display("FAIL exact_max_data[%0d]: got %h, expected %h", d, got_at(base + d), exp[d]);
      end
      vectors++;
      if (trunc_cnt - tbase !== 0) begin
         miscompares++; $display("FAIL exact_max_trunc: got %0d, expected 0", trunc_cnt - tbase);
      end
   endtask

   task automatic test_back_to_back();
      int base, dbase, d, flen;
      bit ok;
      sel   = 1'b1;
      flen  = 60 + FcsLen;
      base  = got.size();
      dbase = done_cnt;
      tx.delete();
      add_frame(60, 13, 8'h10);
      add_frame(60, 29, 8'h77);
      exp.delete();
      build_exp(0, 60, MinB, MaxB);
      build_exp(60, 60, MinB, MaxB);
      drive_tx();
      wait_drain(base + 2 * flen, ok);
      vectors++;
      if (got.size() - base !== 2 * flen) begin
         miscompares++; $display("FAIL b2b_len: got %0d, expected %0d", got.size() - base, 2 * flen);
      end
      d = first_diff(base);
      vectors++;
      if (d !== -1) begin
         miscompares++;
         $display("FAIL b2b_data[%0d]: got %h, expected %h", d, got_at(base + d), exp[d]);
      end
      vectors++;
      if (done_cnt - dbase !== 2) begin
         miscompares++; $display("FAIL b2b_done: got %0d, expected 2", done_cnt - dbase);
      end
      if (got.size() >= base + 2 * flen) begin
         vectors++;
         if (got_cyc[base + flen] - got_cyc[base + flen - 1] !== 1) begin
            miscompares++;
            $display("FAIL b2b_seam_gap: got %0d cycles, expected 1",
                     got_cyc[base + flen] - got_cyc[base + flen - 1]);
         end
         vectors++;
         if (got_cyc[base + 2 * flen - 1] - got_cyc[base] !== 2 * flen - 1) begin
            miscompares++;
            $display("FAIL b2b_span: got %0d cycles, expected %0d",
                     got_cyc[base + 2 * flen - 1] - got_cyc[base], 2 * flen - 1);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int base, dbase, d;
      bit ok;
      sel   = 1'b1;
      dbase = done_cnt;
      tx.delete();
      for (int i = 0; i < 30; i++) tx.push_back({1'b0, 8'(i + 8'h40)});
      drive_tx();
      reset = 1'b1;
      #1;
      vectors++;
      if (obs_en !== 1'b0) begin
         miscompares++; $display("FAIL midrst_enable: got %b, expected 0", obs_en);
      end
      vectors++;
      if (obs_in_ready !== 1'b0) begin
         miscompares++; $display("FAIL midrst_in_ready: got %b, expected 0", obs_in_ready);
      end
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;
      base = got.size();
      tx.delete();
      add_frame(60, 7, 8'h99);
      exp.delete();
      build_exp(0, 60, MinB, MaxB);
      drive_tx();
      wait_drain(base + 60 + FcsLen, ok);
      vectors++;
      if (got.size() - base !== 60 + FcsLen) begin
         miscompares++; $display("FAIL midrst_len: got %0d, expected %0d", got.size() - base, 60 + FcsLen);
      end
      d = first_diff(base);
      vectors++;
      if (d !== -1) begin
         miscompares++;
         $display("FAIL midrst_data[%0d]: got %h, expected %h", d, got_at(base + d), exp[d]);
      end
      vectors++;
      if (done_cnt - dbase !== 1) begin
         miscompares++; $display("FAIL midrst_done: got %0d, expected 1", done_cnt - dbase);
      end
   endtask

   initial begin
      test_reset();
      test_crc_vector();
      test_min_pad();
      test_backpressure();
      test_truncate();
      test_back_to_back();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
